// File: rtl/camara_pkg.sv
// ============================================================================
// Module  : camara_pkg
// Purpose : Shared types and helpers for the camera product classifier.
//           - estado_e   : classifier state encoding
//           - NO_PRODUCT : camera code meaning "empty tray"
//           - stab_cnt_w : width of the saturating stability counter
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package camara_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONFIRM    = 2'd1,
        LOCKED     = 2'd2,
        WAIT_CLEAR = 2'd3
    } estado_e;

    localparam int NO_PRODUCT = 0;

    // Counter must be able to hold the value STABLE_CYCLES itself.
    function automatic int stab_cnt_w(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/camara_filtro_estavel.sv
// ============================================================================
// Module  : camara_filtro_estavel
// Purpose : Saturating run-length counter of consecutive matching samples.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           sample_en    - a sample is presented this cycle
//           match        - the presented sample belongs to the current run
//           restart      - the presented sample starts a new run
//           clear        - force the count to zero (highest priority)
//           stable       - this sample completes STABLE_CYCLES matches
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module camara_filtro_estavel
    import camara_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic match,
    input  logic restart,
    input  logic clear,
    output logic stable
);

    localparam int CW = stab_cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] base;
    logic [CW-1:0] inc;

    always_comb begin
        // A restarting sample counts as the first of a new run.
        base  = restart ? '0 : cnt_q;
        inc   = (base >= SAT) ? SAT : base + 1'b1;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (sample_en) begin
            cnt_d = match ? inc : '0;
        end
        // Decision is made on the sample that completes the run, so it
        // looks at the incremented value rather than the stored one.
        stable = sample_en && match && (inc >= SAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/camara_classificador.sv
// ============================================================================
// Module  : camara_classificador
// Purpose : Debounces camera product codes, reports each confirmed product
//           once through a valid/ack handshake and counts completed
//           transfers. Out-of-table codes raise a one-cycle error pulse.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           cam_valid    - cam_code is a valid sample
//           cam_code     - camera code, 0 = empty tray
//           prod_ack     - consumer accepts prod_id
//           prod_valid   - prod_id holds a confirmed product
//           prod_id      - confirmed product code (stable while valid)
//           unknown_err  - one-cycle pulse for a stable code > N_PRODUCTS
//           busy         - block is not in IDLE
//           prod_count   - completed handshakes, wraps
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module camara_classificador
    import camara_pkg::*;
#(
    parameter int CODE_W        = 3,
    parameter int N_PRODUCTS    = 5,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_valid,
    input  logic [CODE_W-1:0] cam_code,
    input  logic              prod_ack,
    output logic              prod_valid,
    output logic [CODE_W-1:0] prod_id,
    output logic              unknown_err,
    output logic              busy,
    output logic [CNT_W-1:0]  prod_count
);

    localparam logic [CODE_W-1:0] MAX_ID = CODE_W'(N_PRODUCTS);
    localparam logic [CODE_W-1:0] EMPTY  = CODE_W'(NO_PRODUCT);

    estado_e             state_q, state_d;
    logic [CODE_W-1:0]   cand_q, cand_d;
    logic                prod_valid_q, prod_valid_d;
    logic [CODE_W-1:0]   prod_id_q, prod_id_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                code_zero;
    logic                f_sample, f_match, f_restart, f_clear, f_stable;

    // One filter serves both CONFIRM (same nonzero code) and WAIT_CLEAR
    // (empty tray); the FSM steers what counts as a match.
    camara_filtro_estavel #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filtro (
        .clk       (clk),
        .rst       (rst),
        .sample_en (f_sample),
        .match     (f_match),
        .restart   (f_restart),
        .clear     (f_clear),
        .stable    (f_stable)
    );

    assign code_zero = (cam_code == EMPTY);

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        prod_valid_d = prod_valid_q;
        prod_id_d    = prod_id_q;
        err_d        = 1'b0;
        count_d      = count_q;
        f_sample     = 1'b0;
        f_match      = 1'b0;
        f_restart    = 1'b0;

        unique case (state_q)
            IDLE: begin
                f_sample  = cam_valid;
                f_match   = !code_zero;
                f_restart = 1'b1;
                if (cam_valid && !code_zero) begin
                    cand_d  = cam_code;
                    state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                f_sample  = cam_valid;
                f_match   = !code_zero;
                f_restart = cam_valid && (cam_code != cand_q);
                if (cam_valid) begin
                    if (code_zero) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = cam_code;
                    end
                end
            end
            LOCKED: begin
                if (prod_valid_q && prod_ack) begin
                    prod_valid_d = 1'b0;
                    count_d      = count_q + 1'b1;
                    state_d      = WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                f_sample = cam_valid;
                f_match  = code_zero;
                if (f_stable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Decision on the sample that completes the run; the decided code is
        // the current sample (equal to the candidate, or a fresh one when
        // STABLE_CYCLES is 1).
        if ((state_q == IDLE || state_q == CONFIRM) && f_stable) begin
            if (cam_code <= MAX_ID) begin
                state_d      = LOCKED;
                prod_valid_d = 1'b1;
                prod_id_d    = cam_code;
            end else begin
                err_d   = 1'b1;
                state_d = WAIT_CLEAR;
            end
        end

        // Every state entry except IDLE->CONFIRM starts from a zero count;
        // that one keeps the first sample already counted.
        f_clear = (state_d != state_q) && (state_d != CONFIRM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_id_q    <= '0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            prod_valid_q <= prod_valid_d;
            prod_id_q    <= prod_id_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    assign prod_valid  = prod_valid_q;
    assign prod_id     = prod_id_q;
    assign unknown_err = err_q;
    assign busy        = (state_q != IDLE);
    assign prod_count  = count_q;

endmodule

`default_nettype wire

// File: doc/camara_classificador.md
# camara_classificador

Parametrised successor to the camera product-detection block for the supermarket scale. It samples the camera's product code, accepts a code only after it has been stable for a programmable number of valid samples, and presents it to the scale/pricing logic through a valid/ack handshake. It rejects codes outside the product table, and does not count the same product twice until the tray is seen empty again. It sits between the camera interface and the weighing/pricing controller.

## Interface
- CODE_W, 3: width of the camera code and of prod_id.
- N_PRODUCTS, 5: highest legal product code. Codes 1..N_PRODUCTS are products. Constraint: 1 ≤ N_PRODUCTS ≤ 2^CODE_W−1.
- STABLE_CYCLES, 4: consecutive matching valid samples required to accept a code (≥1).
- CNT_W, 8: width of the accepted-product counter.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- cam_valid, input, 1: cam_code is a valid sample this cycle.
- cam_code, input, CODE_W: camera code; 0 = empty tray (NO_PRODUCT).
- prod_ack, input, 1: consumer accepts prod_id.
- prod_valid, output, 1: prod_id holds a confirmed product.
- prod_id, output, CODE_W: confirmed product code.
- unknown_err, output, 1: one-cycle pulse when a stable code is greater than N_PRODUCTS.
- busy, output, 1: high in every state except IDLE.
- prod_count, output, CNT_W: number of completed handshakes; wraps modulo 2^CNT_W.

## Operation
- The state machine has four states: IDLE, CONFIRM, LOCKED and WAIT_CLEAR.
- A cycle with cam_valid = 0 is ignored in every state. State, candidate and stability count are all frozen.
- **IDLE**
  - A valid nonzero sample sets cand ← cam_code and cnt ← 1, then moves to CONFIRM.
  - If STABLE_CYCLES = 1, the decision is made on that same sample instead (see the decision step below).
  - A valid zero sample stays in IDLE.
- **CONFIRM**
  - A valid sample equal to cand increments cnt.
  - When cnt reaches STABLE_CYCLES, the block decides:
    - cand ≤ N_PRODUCTS: go to LOCKED, with prod_id ← cand and prod_valid ← 1.
    - Otherwise: pulse unknown_err for one cycle and go to WAIT_CLEAR.
  - A valid, different, nonzero sample restarts the count: cand ← cam_code, cnt ← 1.
  - A valid zero sample returns to IDLE.
- **LOCKED**
  - prod_valid and prod_id are held stable; camera samples are ignored.
  - When prod_valid & prod_ack: prod_valid falls on the next cycle, prod_count increments, and the state moves to WAIT_CLEAR.
- **WAIT_CLEAR**
  - Requires STABLE_CYCLES consecutive valid zero samples, then returns to IDLE.
  - Any valid nonzero sample resets this count to 0.
  - This prevents re-detecting a product that was never removed.
- The stability counter is $clog2(STABLE_CYCLES+1) bits wide and saturates; it never wraps.
- Reset values: state IDLE; prod_valid 0, prod_id 0, unknown_err 0, busy 0, prod_count 0.
- Reset asserted mid-operation (including LOCKED with no ack) discards the pending product. prod_count is also cleared.

## Timing
- Accept latency:
  - First nonzero valid sample at edge k, followed by matching valid samples on every cycle.
  - prod_valid is high after edge k+STABLE_CYCLES−1, i.e. STABLE_CYCLES samples in total.
  - Each cam_valid gap adds one cycle of latency per invalid cycle.
- unknown_err asserts in the same cycle that prod_valid would have risen, and lasts exactly one cycle.
- Handshake:
  - prod_ack may already be high when prod_valid rises; the transfer then completes at the next edge.
  - prod_ack while prod_valid = 0 has no effect.
  - prod_id must not change while prod_valid = 1.
- prod_count updates on the same edge that clears prod_valid.
- Earliest re-arm after a handshake is STABLE_CYCLES empty samples later.
- Back-to-back products therefore take at least 2·STABLE_CYCLES+1 cycles.

## Structure
- Package camara_pkg holds:
  - the state enum (IDLE, CONFIRM, LOCKED, WAIT_CLEAR);
  - the NO_PRODUCT = '0 constant;
  - a function for the stability counter width.
- Optional sub-module camara_filtro_estavel contains the reusable match/count/saturate logic, with inputs sample_en, match and restart and output stable.
- This sub-module is instantiated once and shared by CONFIRM and WAIT_CLEAR; the FSM selects its match condition per state.

## Test plan
- Defaults; cam_code = 3 valid for 4 cycles, prod_ack high → prod_valid high one cycle with prod_id = 3; prod_count = 1; busy returns to 0 after 4 empty samples.
- cam_code sequence 2,2,5,5,5,5 → the candidate restarts at 5; only prod_id = 5 is reported. The initial 2 never appears.
- cam_code = 7 stable for 4 valid cycles → unknown_err pulses once; prod_valid stays 0; prod_count unchanged; block waits for empty tray.
- Product 4 locked, prod_ack held low for 20 cycles with cam_code going to 0 → prod_valid and prod_id = 4 held throughout; the later ack completes normally.
- cam_valid toggling every other cycle with cam_code = 1 → prod_valid rises after 4 valid samples (about 7–8 cycles).
- After a handshake, product 2 kept on the tray for 50 cycles → no second detection. Then remove it for 4 samples and re-present it → second detection; prod_count = 2.
- CNT_W = 2, five full handshakes → prod_count wraps to 1.
- rst pulsed while in LOCKED → all outputs return to their reset values on the next cycle.
